// File: rtl/video_scanout.sv
// Display timing generator and scan-out stage.
// It sweeps the raster, drives the frame-buffer read address and expands
// each registered RGB332 pixel to 24-bit RGB. Sync and data-enable leave on
// the same clock as the pixel they belong to.
module video_scanout #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic [9:0] rdaddress_x,
  output logic [9:0] rdaddress_y,
  input  logic [7:0] read_data,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_S = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_E = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_S = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_E = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] h_count;
  logic [9:0] v_count;
  logic       h_vis;
  logic       v_vis;
  logic       act;
  logic       hs;
  logic       vs;
  logic       first;

  logic       vld_p1;
  logic       hs_p1;
  logic       vs_p1;
  logic       first_p1;

  // RGB332 to RGB888 by bit replication so full-scale codes reach 0xFF.
  function automatic logic [23:0] expand_rgb332(input logic [7:0] pix);
    return {pix[7:5], pix[7:5], pix[7:6],
            pix[4:2], pix[4:2], pix[4:3],
            {4{pix[1:0]}}};
  endfunction

  // Raster counters: h wraps every line, v advances on the h wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_count <= '0;
      v_count <= '0;
    end else if (h_count == H_LAST) begin
      h_count <= '0;
      v_count <= (v_count == V_LAST) ? 10'd0 : v_count + 10'd1;
    end else begin
      h_count <= h_count + 10'd1;
    end
  end

  // Raw timing and read address decoded straight from the counters; the
  // address is held at 0 in blanking so it never leaves the buffer.
  always_comb begin
    h_vis       = (h_count < H_ACT);
    v_vis       = (v_count < V_ACT);
    act         = h_vis && v_vis;
    hs          = (h_count >= H_SYNC_S) && (h_count < H_SYNC_E);
    vs          = (v_count >= V_SYNC_S) && (v_count < V_SYNC_E);
    first       = (h_count == 10'd0) && (v_count == 10'd0);
    rdaddress_x = h_vis ? h_count : 10'd0;
    rdaddress_y = v_vis ? v_count : 10'd0;
  end

  // ---- stage p1: timing delayed one clock to meet the buffer's read_data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1   <= 1'b0;
      hs_p1    <= 1'b0;
      vs_p1    <= 1'b0;
      first_p1 <= 1'b0;
    end else begin
      vld_p1   <= act;
      hs_p1    <= hs;
      vs_p1    <= vs;
      first_p1 <= first;
    end
  end

  // ---- stage p2: registered outputs, pixel blanked whenever de is low
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      de                 <= 1'b0;
      frame_start        <= 1'b0;
      hsync              <= ~SYNC_POL;
      vsync              <= ~SYNC_POL;
      {red, green, blue} <= '0;
    end else begin
      de                 <= vld_p1;
      frame_start        <= first_p1;
      hsync              <= hs_p1 ? SYNC_POL : ~SYNC_POL;
      vsync              <= vs_p1 ? SYNC_POL : ~SYNC_POL;
      {red, green, blue} <= vld_p1 ? expand_rgb332(read_data) : 24'h0;
    end
  end

endmodule

// File: tb/tb_video_scanout.sv
// Bench for video_scanout: a full-size instance (A) for line timing, pixel
// expansion and mid-line reset, and a tiny-raster, positive-sync instance (B)
// whose whole frames fit in a short run. A per-cycle reference model tracks
// the output raster position of each instance.
module tb_video_scanout;

  logic       clk;
  logic       reset_n;

  logic [9:0] rdaddress_x_a, rdaddress_y_a;
  logic [7:0] read_data_a;
  logic [7:0] red_a, green_a, blue_a;
  logic       hsync_a, vsync_a, de_a, frame_start_a;

  logic [9:0] rdaddress_x_b, rdaddress_y_b;
  logic [7:0] read_data_b;
  logic [7:0] red_b, green_b, blue_b;
  logic       hsync_b, vsync_b, de_b, frame_start_b;

  video_scanout dut_a (
    .clk(clk), .reset_n(reset_n),
    .rdaddress_x(rdaddress_x_a), .rdaddress_y(rdaddress_y_a),
    .read_data(read_data_a),
    .red(red_a), .green(green_a), .blue(blue_a),
    .hsync(hsync_a), .vsync(vsync_a), .de(de_a), .frame_start(frame_start_a)
  );

  video_scanout #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b1)
  ) dut_b (
    .clk(clk), .reset_n(reset_n),
    .rdaddress_x(rdaddress_x_b), .rdaddress_y(rdaddress_y_b),
    .read_data(read_data_b),
    .red(red_b), .green(green_b), .blue(blue_b),
    .hsync(hsync_b), .vsync(vsync_b), .de(de_b), .frame_start(frame_start_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  function automatic logic [23:0] exp_rgb(input logic [7:0] p);
    logic [8:0] r9;
    logic [8:0] g9;
    r9 = {p[7:5], p[7:5], p[7:5]};
    g9 = {p[4:2], p[4:2], p[4:2]};
    return {r9[8:1], g9[8:1], {4{p[1:0]}}};
  endfunction

  // Frame-buffer models: 1-clock registered read returning x ^ y. Instance A
  // can instead be fed a constant pixel straight onto read_data.
  logic       mode;
  logic [7:0] cpix;
  logic [7:0] buf_a, buf_b;
  logic       mode_q;
  logic [7:0] cpix_q;

  always @(posedge clk) begin
    buf_a  <= rdaddress_x_a[7:0] ^ rdaddress_y_a[7:0];
    buf_b  <= rdaddress_x_b[7:0] ^ rdaddress_y_b[7:0];
    mode_q = mode;
    cpix_q = cpix;
  end
  assign read_data_a = mode ? cpix : buf_a;
  assign read_data_b = buf_b;

  // Expected outputs for output position (h,v); returns one bit per mismatching
  // signal group: de, hsync, vsync, frame_start, rgb, read address.
  function automatic logic [5:0] chk(
    input int ha, input int hf, input int hsw, input int hb,
    input int va, input int vf, input int vsw, input int vb,
    input logic pol, input int h, input int v, input logic [7:0] pix,
    input logic de_o, input logic hs_o, input logic vs_o, input logic fs_o,
    input logic [23:0] rgb_o, input logic [9:0] ax, input logic [9:0] ay);
    logic [5:0] m;
    logic act;
    int ht, vt, nh, nv;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    act = (h < ha) && (v < va);
    m[0] = (de_o !== act);
    m[1] = (hs_o !== (((h >= ha + hf) && (h < ha + hf + hsw)) ? pol : ~pol));
    m[2] = (vs_o !== (((v >= va + vf) && (v < va + vf + vsw)) ? pol : ~pol));
    m[3] = (fs_o !== ((h == 0) && (v == 0)));
    m[4] = (rgb_o !== (act ? exp_rgb(pix) : 24'h0));
    nh = h + 2;
    nv = v;
    if (nh >= ht) begin
      nh = nh - ht;
      nv = nv + 1;
      if (nv >= vt) nv = 0;
    end
    m[5] = (ax !== 10'((nh < ha) ? nh : 0)) || (ay !== 10'((nv < va) ? nv : 0));
    return m;
  endfunction

  int ncyc_a, h_a, v_a;
  int ncyc_b, h_b, v_b;
  int err_a[6] = '{default: 0};
  int err_b[6] = '{default: 0};
  int de_cnt_b, vs_cnt_b, hs_edge_b, frames_b;
  logic hs_prev_b;

  // Monitor A: from the second clock after reset release, output position
  // advances one pixel per clock starting at (0,0).
  always @(negedge clk) begin : mon_a
    logic [5:0] m;
    logic [7:0] px;
    if (!reset_n) begin
      ncyc_a = 0;
    end else begin
      ncyc_a++;
      if (ncyc_a == 2) begin
        h_a = 0;
        v_a = 0;
      end
      if (ncyc_a >= 2) begin
        px = mode_q ? cpix_q : 8'(h_a ^ v_a);
        m = chk(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, h_a, v_a, px,
                de_a, hsync_a, vsync_a, frame_start_a, {red_a, green_a, blue_a},
                rdaddress_x_a, rdaddress_y_a);
        for (int i = 0; i < 6; i++) if (m[i]) err_a[i]++;
        h_a++;
        if (h_a == 800) begin
          h_a = 0;
          v_a++;
          if (v_a == 525) v_a = 0;
        end
      end
    end
  end

  // Monitor B: same model on the 15x8 raster, plus per-frame totals.
  always @(negedge clk) begin : mon_b
    logic [5:0] m;
    if (!reset_n) begin
      ncyc_b = 0;
      frames_b = 0;
    end else begin
      ncyc_b++;
      if (ncyc_b == 2) begin
        h_b = 0;
        v_b = 0;
        de_cnt_b = 0;
        vs_cnt_b = 0;
        hs_edge_b = 0;
        hs_prev_b = 1'b0;
      end
      if (ncyc_b >= 2) begin
        m = chk(8, 2, 3, 2, 4, 1, 2, 1, 1'b1, h_b, v_b, 8'(h_b ^ v_b),
                de_b, hsync_b, vsync_b, frame_start_b, {red_b, green_b, blue_b},
                rdaddress_x_b, rdaddress_y_b);
        for (int i = 0; i < 6; i++) if (m[i]) err_b[i]++;
        if (de_b) de_cnt_b++;
        if (vsync_b) vs_cnt_b++;
        if (hsync_b && !hs_prev_b) hs_edge_b++;
        hs_prev_b = hsync_b;
        h_b++;
        if (h_b == 15) begin
          h_b = 0;
          v_b++;
          if (v_b == 8) begin
            v_b = 0;
            check("b_frame_de_clocks", 32'(de_cnt_b), 32'd32);
            check("b_frame_hsync_pulses", 32'(hs_edge_b), 32'd8);
            check("b_frame_vsync_clocks", 32'(vs_cnt_b), 32'd30);
            frames_b++;
            de_cnt_b = 0;
            vs_cnt_b = 0;
            hs_edge_b = 0;
          end
        end
      end
    end
  end

  typedef struct {
    logic [7:0]  pix;
    logic [23:0] rgb;
  } vec_t;

  vec_t tbl[6];

  // Release reset between clock edges, then expect de and frame_start to rise
  // together on the second clock.
  task automatic release_and_check(input string tag);
    @(negedge clk);
    #2 reset_n = 1'b1;
    #1;
    check({tag, "_addr_x"}, 32'(rdaddress_x_a), 32'd0);
    check({tag, "_addr_y"}, 32'(rdaddress_y_a), 32'd0);
    @(negedge clk);
    check({tag, "_de_clk1"}, 32'(de_a), 32'd0);
    @(negedge clk);
    check({tag, "_de_clk2"}, 32'(de_a), 32'd1);
    check({tag, "_fs_clk2"}, 32'(frame_start_a), 32'd1);
    check({tag, "_rgb_clk2"}, 32'({red_a, green_a, blue_a}), 32'(exp_rgb(8'h00)));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_de"}, 32'(de_a), 32'd0);
    check({tag, "_fs"}, 32'(frame_start_a), 32'd0);
    check({tag, "_rgb"}, 32'({red_a, green_a, blue_a}), 32'd0);
    check({tag, "_hsync_a"}, 32'(hsync_a), 32'd1);
    check({tag, "_vsync_a"}, 32'(vsync_a), 32'd1);
    check({tag, "_addr_a"}, 32'({rdaddress_x_a, rdaddress_y_a}), 32'd0);
    check({tag, "_hsync_b"}, 32'(hsync_b), 32'd0);
    check({tag, "_vsync_b"}, 32'(vsync_b), 32'd0);
  endtask

  string cat[6] = '{"de", "hsync", "vsync", "frame_start", "rgb", "rdaddr"};

  initial begin
    int t_defall, t_hsfall1, t_hsrise, t_hsfall2;
    logic pde, phs, found;

    tbl[0] = '{8'hFF, 24'hFFFFFF};
    tbl[1] = '{8'hE0, 24'hFF0000};
    tbl[2] = '{8'h1C, 24'h00FF00};
    tbl[3] = '{8'h03, 24'h0000FF};
    tbl[4] = '{8'h00, 24'h000000};
    tbl[5] = '{8'h49, 24'h494955};

    mode    = 1'b0;
    cpix    = 8'h00;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    release_and_check("rel1");

    // Line timing on A measured from the first de of line 0.
    t_defall = -1; t_hsfall1 = -1; t_hsrise = -1; t_hsfall2 = -1;
    pde = 1'b1;
    phs = 1'b1;
    for (int t = 1; t <= 1700; t++) begin
      @(negedge clk);
      if (pde && !de_a && t_defall < 0) t_defall = t;
      if (phs && !hsync_a) begin
        if (t_hsfall1 < 0) t_hsfall1 = t;
        else if (t_hsfall2 < 0) t_hsfall2 = t;
      end
      if (!phs && hsync_a && t_hsrise < 0) t_hsrise = t;
      pde = de_a;
      phs = hsync_a;
    end
    check("de_run_length", 32'(t_defall), 32'd640);
    check("hsync_offset", 32'(t_hsfall1), 32'd656);
    check("hsync_width", 32'(t_hsrise - t_hsfall1), 32'd96);
    check("hsync_period", 32'(t_hsfall2 - t_hsfall1), 32'd800);

    // Reset asserted mid-line (around pixel 300 of line 2) between edges.
    found = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      #1;
      if (h_a == 300 && v_a == 2) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) check("midreset_wait_timeout", 32'd0, 32'd1);
    check("pre_reset_de", 32'(de_a), 32'd1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    release_and_check("rel2");

    // Expansion vectors: constant pixel on read_data, sampled on an active clock.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      mode = 1'b1;
      cpix = tbl[i].pix;
      repeat (2) @(negedge clk);
      found = 1'b0;
      for (int k = 0; k < 2000; k++) begin
        if (de_a) begin
          found = 1'b1;
          break;
        end
        @(negedge clk);
      end
      if (found) check($sformatf("expand_%02h", tbl[i].pix),
                       32'({red_a, green_a, blue_a}), 32'(tbl[i].rgb));
      else check("expand_wait_timeout", 32'd0, 32'd1);
    end

    // Blanking with an all-ones pixel: first clock after de falls.
    @(negedge clk);
    #1;
    cpix = 8'hFF;
    found = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (de_a) begin
        found = 1'b1;
        break;
      end
    end
    if (found) begin
      found = 1'b0;
      for (int k = 0; k < 2000; k++) begin
        @(negedge clk);
        if (!de_a) begin
          found = 1'b1;
          break;
        end
      end
    end
    if (found) begin
      check("blank_rgb", 32'({red_a, green_a, blue_a}), 32'd0);
      check("blank_addr_x", 32'(rdaddress_x_a), 32'd0);
    end else begin
      check("blank_wait_timeout", 32'd0, 32'd1);
    end

    @(negedge clk);
    #1;
    mode = 1'b0;
    repeat (400) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      check({"a_scan_", cat[i]}, 32'(err_a[i]), 32'd0);
      check({"b_scan_", cat[i]}, 32'(err_b[i]), 32'd0);
    end
    check("b_frames_seen", 32'(frames_b >= 3), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
